// File: rtl/sbio_pkg.sv
// Shared codes, default geometry and state types for the serial-bus read port.
package sbio_pkg;

  localparam int IO_BITS        = 2;
  localparam int PAYLOAD_CYCLES = 8;
  localparam int WORD_SIZE      = IO_BITS * PAYLOAD_CYCLES;

  localparam logic [1:0] TX_SOURCE_SCAN = 2'd1;
  localparam logic [1:0] TX_SOURCE_READ = 2'd2;
  localparam logic [1:0] TX_SOURCE_OUT  = 2'd3;

  localparam logic [1:0] RX_SB_SCAN  = 2'd1;
  localparam logic [1:0] RX_SB_READ  = 2'd2;
  localparam logic [1:0] RX_SB_WRITE = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_HEADER,
    TX_PAYLOAD
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_PAYLOAD
  } rx_state_e;

  // Counter/pointer width that never collapses to zero bits.
  function automatic int clog2_min1(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sbio_resp_fifo.sv
// Small response FIFO; push and pop in the same cycle are legal even when full.
module sbio_resp_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       empty,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import sbio_pkg::*;

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sbio_read_port.sv
// Host-side serial read port: sends read requests on tx_pins, parses rx_pins frames.
//   state      | meaning
//   TX_IDLE    | tx_pins=0, may accept a read request
//   TX_START   | start symbol 01
//   TX_HEADER  | source code TX_SOURCE_READ
//   TX_PAYLOAD | address, IO_BITS per cycle, LSB first
//   RX_IDLE    | waiting for a nonzero start symbol
//   RX_PAYLOAD | shifting in the payload, LSB first
module sbio_read_port #(
  parameter  int IO_BITS         = 2,
  parameter  int PAYLOAD_CYCLES  = 8,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int WORD_SIZE       = IO_BITS * PAYLOAD_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [IO_BITS-1:0]   tx_pins,
  input  logic [IO_BITS-1:0]   rx_pins,
  input  logic                 rd_req_valid,
  output logic                 rd_req_ready,
  input  logic [WORD_SIZE-1:0] rd_req_addr,
  output logic                 rd_resp_valid,
  input  logic                 rd_resp_ready,
  output logic [WORD_SIZE-1:0] rd_resp_data,
  output logic                 wr_valid,
  output logic [7:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic                 rd_resp_unexpected
);
  import sbio_pkg::*;

  localparam int CNT_W = clog2_min1(PAYLOAD_CYCLES);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PAYLOAD_CYCLES-1);

  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [WORD_SIZE-1:0] addr_q;
  logic [IO_BITS-1:0]   tx_pins_q, tx_pins_d;
  logic [OUT_W-1:0]     outstanding_q;
  logic                 req_fire;
  logic                 pop_fire;

  rx_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IO_BITS-1:0]   rx_sb_q;
  logic [WORD_SIZE-1:0] rx_shift_q;
  logic [WORD_SIZE-1:0] rx_word;
  logic                 rx_last;
  logic                 rsp_push;
  logic                 unexp_d;
  logic                 wr_d;
  logic                 wr_valid_q;
  logic                 unexp_q;
  logic [7:0]           wr_addr_q, wr_data_q;

  logic                 fifo_empty;
  logic [OUT_W-1:0]     fifo_count;

  // Gated with reset_n so the port reads not-ready while reset is held.
  assign rd_req_ready = reset_n && (tx_state_q == TX_IDLE) &&
                        (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  assign req_fire     = rd_req_valid && rd_req_ready;
  assign rd_resp_valid = !fifo_empty;
  assign pop_fire     = rd_resp_valid && rd_resp_ready;

  assign tx_pins            = tx_pins_q;
  assign wr_valid           = wr_valid_q;
  assign wr_addr            = wr_addr_q;
  assign wr_data            = wr_data_q;
  assign rd_resp_unexpected = unexp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      addr_q        <= '0;
      tx_pins_q     <= '0;
      outstanding_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_pins_q  <= tx_pins_d;
      if (req_fire) addr_q <= rd_req_addr;
      case ({req_fire, pop_fire})
        2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    case (tx_state_q)
      TX_IDLE:   if (req_fire) tx_state_d = TX_START;
      TX_START:  tx_state_d = TX_HEADER;
      TX_HEADER: begin
        tx_state_d = TX_PAYLOAD;
        tx_cnt_d   = '0;
      end
      TX_PAYLOAD: begin
        if (tx_cnt_q == LAST) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // tx_pins is registered, so its value is decoded from the upcoming state.
  always_comb begin
    tx_pins_d = '0;
    case (tx_state_d)
      TX_START:   tx_pins_d = IO_BITS'(1);
      TX_HEADER:  tx_pins_d = IO_BITS'(TX_SOURCE_READ);
      TX_PAYLOAD: tx_pins_d = addr_q[int'(tx_cnt_d)*IO_BITS +: IO_BITS];
      default:    tx_pins_d = '0;
    endcase
  end

  assign rx_last = (rx_state_q == RX_PAYLOAD) && (rx_cnt_q == LAST);
  assign rx_word = {rx_pins, rx_shift_q[WORD_SIZE-1:IO_BITS]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_sb_q    <= '0;
      rx_shift_q <= '0;
      wr_valid_q <= 1'b0;
      unexp_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      if (rx_state_q == RX_IDLE && rx_pins != '0) rx_sb_q <= rx_pins;
      if (rx_state_q == RX_PAYLOAD) rx_shift_q <= rx_word;
      wr_valid_q <= wr_d;
      unexp_q    <= unexp_d;
      if (wr_d) begin
        wr_addr_q <= rx_word[15:8];
        wr_data_q <= rx_word[7:0];
      end
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_pins != '0) begin
          rx_state_d = RX_PAYLOAD;
          rx_cnt_d   = '0;
        end
      end
      RX_PAYLOAD: begin
        if (rx_cnt_q == LAST) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A read response is only expected while some request is still in flight
  // (sent, and not already sitting in the FIFO).
  always_comb begin
    rsp_push = 1'b0;
    unexp_d  = 1'b0;
    wr_d     = 1'b0;
    if (rx_last) begin
      if (rx_sb_q == IO_BITS'(RX_SB_READ)) begin
        rsp_push = (outstanding_q > fifo_count);
        unexp_d  = !(outstanding_q > fifo_count);
      end else if (rx_sb_q == IO_BITS'(RX_SB_WRITE)) begin
        wr_d = 1'b1;
      end
    end
  end

  sbio_resp_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rsp_push),
    .push_data (rx_word),
    .pop       (pop_fire),
    .empty     (fifo_empty),
    .head      (rd_resp_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sbio_read_port.sv
// Self-checking bench for sbio_read_port: frame table plus hand-written corner sequences.
module tb_sbio_read_port;
  import sbio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  tx_pins;
  logic [1:0]  rx_pins;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [15:0] rd_req_addr;
  logic        rd_resp_valid;
  logic        rd_resp_ready;
  logic [15:0] rd_resp_data;
  logic        wr_valid;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        rd_resp_unexpected;

  sbio_read_port #(.IO_BITS(2), .PAYLOAD_CYCLES(8), .MAX_OUTSTANDING(2)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .tx_pins            (tx_pins),
    .rx_pins            (rx_pins),
    .rd_req_valid       (rd_req_valid),
    .rd_req_ready       (rd_req_ready),
    .rd_req_addr        (rd_req_addr),
    .rd_resp_valid      (rd_resp_valid),
    .rd_resp_ready      (rd_resp_ready),
    .rd_resp_data       (rd_resp_data),
    .wr_valid           (wr_valid),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .rd_resp_unexpected (rd_resp_unexpected)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          n_wr;
  int          n_unexp;
  logic [15:0] exp_q[$];

  typedef struct {
    bit          do_req;
    logic [15:0] addr;
    logic [1:0]  sb;
    logic [15:0] payload;
    int          exp_wr;
    int          exp_unexp;
    bit          exp_resp;
    logic [7:0]  exp_wa;
    logic [7:0]  exp_wd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] chunk(logic [15:0] a, int k);
    logic [15:0] s;
    s = a >> (2 * k);
    return s[1:0];
  endfunction

  task automatic sample();
    if (wr_valid) n_wr++;
    if (rd_resp_unexpected) n_unexp++;
  endtask

  task automatic send_req(logic [15:0] addr);
    int waited = 0;
    logic [1:0] exp;
    while (!rd_req_ready && waited < 50) begin
      step();
      waited++;
    end
    chk("req_ready_wait", rd_req_ready, 1);
    if (rd_req_ready) begin
      rd_req_valid = 1'b1;
      rd_req_addr  = addr;
      step();
      rd_req_valid = 1'b0;
      chk("ready_low_in_frame", rd_req_ready, 0);
      for (int i = 0; i < 11; i++) begin
        if (i == 0)       exp = 2'b01;
        else if (i == 1)  exp = TX_SOURCE_READ;
        else if (i < 10)  exp = chunk(addr, i - 2);
        else              exp = 2'b00;
        chk($sformatf("tx_pins[%0d] addr=%h", i, addr), tx_pins, exp);
        if (i < 10) step();
      end
    end
  endtask

  task automatic drive_frame(logic [1:0] sb, logic [15:0] payload);
    rx_pins = sb;
    step();
    sample();
    for (int k = 0; k < 8; k++) begin
      rx_pins = chunk(payload, k);
      step();
      sample();
    end
    rx_pins = 2'b00;
  endtask

  task automatic idle(int n);
    rx_pins = 2'b00;
    for (int k = 0; k < n; k++) begin
      step();
      sample();
    end
  endtask

  task automatic pop_resp();
    logic [15:0] e;
    chk("resp_valid_before_pop", rd_resp_valid, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("resp_data", rd_resp_data, e);
    end
    rd_resp_ready = 1'b1;
    step();
    rd_resp_ready = 1'b0;
    chk("resp_valid_after_pop", rd_resp_valid, (exp_q.size() != 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 16'hA5C3, 2'd2, 16'h1234, 0, 0, 1'b1, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 16'h0000, 2'd3, 16'h4203, 1, 0, 1'b0, 8'h42, 8'h03};
    vecs[2] = '{1'b0, 16'h0000, 2'd2, 16'hBEEF, 0, 1, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 16'h0000, 2'd1, 16'hFFFF, 0, 0, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 16'hFFFF, 2'd2, 16'h0001, 0, 0, 1'b1, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 16'h0001, 2'd3, 16'h00FF, 1, 0, 1'b0, 8'h00, 8'hFF};
    vecs[6] = '{1'b0, 16'h0000, 2'd2, 16'h8000, 0, 0, 1'b1, 8'h00, 8'h00};

    reset_n       = 1'b0;
    rx_pins       = 2'b00;
    rd_req_valid  = 1'b0;
    rd_req_addr   = 16'h0000;
    rd_resp_ready = 1'b0;
    #12;
    chk("rst_tx_pins", tx_pins, 0);
    chk("rst_req_ready", rd_req_ready, 0);
    chk("rst_resp_valid", rd_resp_valid, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_unexpected", rd_resp_unexpected, 0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", rd_req_ready, 1);
    step();

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_req) send_req(vecs[v].addr);
      n_wr = 0;
      n_unexp = 0;
      drive_frame(vecs[v].sb, vecs[v].payload);
      idle(4);
      if (vecs[v].exp_resp) exp_q.push_back(vecs[v].payload);
      chk($sformatf("vec%0d wr_pulses", v), n_wr, vecs[v].exp_wr);
      chk($sformatf("vec%0d unexp_pulses", v), n_unexp, vecs[v].exp_unexp);
      chk($sformatf("vec%0d resp_valid", v), rd_resp_valid, vecs[v].exp_resp);
      if (vecs[v].exp_wr != 0) begin
        chk($sformatf("vec%0d wr_addr", v), wr_addr, vecs[v].exp_wa);
        chk($sformatf("vec%0d wr_data", v), wr_data, vecs[v].exp_wd);
      end
      if (vecs[v].exp_resp) pop_resp();
    end

    // Two outstanding requests block further requests until a response pops.
    send_req(16'h1111);
    send_req(16'h2222);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ready_blocked_at_max", rd_req_ready, 0);
    end
    n_wr = 0;
    n_unexp = 0;
    drive_frame(2'd2, 16'h1234);
    exp_q.push_back(16'h1234);
    idle(2);
    chk("ready_blocked_before_pop", rd_req_ready, 0);
    pop_resp();
    chk("ready_after_pop", rd_req_ready, 1);
    drive_frame(2'd2, 16'h5678);
    exp_q.push_back(16'h5678);
    idle(2);
    pop_resp();
    chk("max_out_unexp", n_unexp, 0);

    // Read frame immediately followed by a scan frame, no gap.
    send_req(16'h0F0F);
    n_wr = 0;
    n_unexp = 0;
    drive_frame(2'd2, 16'hCAFE);
    drive_frame(2'd1, 16'hFFFF);
    idle(3);
    exp_q.push_back(16'hCAFE);
    chk("b2b_unexp", n_unexp, 0);
    chk("b2b_wr", n_wr, 0);
    pop_resp();

    // Reset while the header symbol is on the wire.
    while (!rd_req_ready) step();
    rd_req_valid = 1'b1;
    rd_req_addr  = 16'h7777;
    step();
    rd_req_valid = 1'b0;
    step();
    chk("hdr_before_reset", tx_pins, TX_SOURCE_READ);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_tx_pins_async", tx_pins, 0);
    chk("reset_ready_async", rd_req_ready, 0);
    chk("reset_resp_valid", rd_resp_valid, 0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    chk("release_ready", rd_req_ready, 1);
    chk("release_tx_pins", tx_pins, 0);
    step();
    chk("post_release_idle", tx_pins, 0);
    send_req(16'h3C5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sbio_read_port.md
SBIO_READ_PORT -- requirements
Module: sbio_read_port

Interface
REQ-001 SHALL have parameter IO_BITS, default 2, serial lane width.
REQ-002 SHALL have parameter PAYLOAD_CYCLES, default 8, payload cycles per frame; WORD_SIZE = IO_BITS*PAYLOAD_CYCLES (16).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, reads sent but not yet popped from the response FIFO.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tx_pins  out  IO_BITS  serial output to host.
REQ-007 SHALL have port rx_pins  in  IO_BITS  serial input from host.
REQ-008 SHALL have ports rd_req_valid in 1, rd_req_ready out 1, rd_req_addr in WORD_SIZE  read request handshake.
REQ-009 SHALL have ports rd_resp_valid out 1, rd_resp_ready in 1, rd_resp_data out WORD_SIZE  read response handshake.
REQ-010 SHALL have ports wr_valid out 1, wr_addr out 8, wr_data out 8  host register-write strobe.
REQ-011 SHALL have port rd_resp_unexpected  out  1  one-cycle pulse on a dropped read response.

Function
REQ-012 TX FSM SHALL have states IDLE, START, HEADER, PAYLOAD (cycle counter 0..PAYLOAD_CYCLES-1); PAYLOAD at counter 7 -> IDLE.
REQ-013 rd_req_ready SHALL be high only in IDLE with outstanding < MAX_OUTSTANDING; handshake = valid && ready, latches addr, IDLE -> START next cycle.
REQ-014 tx_pins SHALL be 2'b01 in START, TX_SOURCE_READ in HEADER, addr[2k+1:2k] in PAYLOAD cycle k (LSB first), 0 in IDLE; all registered.
REQ-015 Consecutive TX frames SHALL be separated by at least one IDLE cycle (11 cycles minimum per request).
REQ-016 RX SHALL idle while rx_pins==0; first nonzero cycle is the start cycle, start bits latched; next PAYLOAD_CYCLES cycles shift rx_pins in LSB first.
REQ-017 RX SHALL accept a new start bit in the cycle right after the last payload cycle.
REQ-018 On frame completion with start bits RX_SB_READ: push payload to response FIFO if inflight (outstanding - fifo_count) > 0, else drop and pulse rd_resp_unexpected next cycle.
REQ-019 On completion with RX_SB_WRITE: wr_valid SHALL pulse exactly one cycle, next cycle, wr_addr=payload[15:8], wr_data=payload[7:0]; wr_addr/wr_data hold until the next write.
REQ-020 Frames with RX_SB_SCAN SHALL be consumed and discarded without side effects.
REQ-021 rd_resp_valid SHALL equal FIFO non-empty; rd_resp_data = FIFO head; a push in cycle N is visible in cycle N+1; pop on valid && ready.
REQ-022 outstanding SHALL increment on request handshake and decrement on response pop; both in one cycle -> unchanged.
REQ-023 FIFO depth SHALL equal MAX_OUTSTANDING; overflow is unreachable by REQ-018/REQ-022; a simultaneous push and pop on a full FIFO SHALL be legal.
REQ-024 TX and RX SHALL operate concurrently and independently.

Reset
REQ-025 reset_n low SHALL asynchronously force: tx_pins=0, rd_req_ready=0, rd_resp_valid=0, wr_valid=0, wr_addr=0, wr_data=0, rd_resp_unexpected=0, FSMs IDLE, FIFO empty, outstanding=0.
REQ-026 Reset mid-frame SHALL abandon the frame; the first post-reset cycle SHALL be IDLE with rd_req_ready=1.

Structure
REQ-027 Package sbio_pkg SHALL hold TX_SOURCE_SCAN/READ/OUT codes, RX_SB_SCAN=2'd1, RX_SB_READ=2'd2, RX_SB_WRITE=2'd3, IO_BITS, PAYLOAD_CYCLES, WORD_SIZE, and the TX/RX state enums.
REQ-028 The response FIFO SHALL be a sub-module sbio_resp_fifo (parameters WIDTH, DEPTH; same clk/reset_n).

Verification
REQ-029 Request addr=0xA5C3 -> tx_pins: 01, TX_SOURCE_READ, then 3,0,0,3,1,1,2,2, then 0.
REQ-030 Two requests, no responses -> rd_req_ready stays 0 after the second; RX_SB_READ frame with payload 0x1234 -> rd_resp_data=0x1234, and ready returns only after the pop.
REQ-031 RX frame sb=3, payload 0x4203 -> one wr_valid pulse, wr_addr=0x42, wr_data=0x03.
REQ-032 RX_SB_READ frame with outstanding=0 -> rd_resp_unexpected pulses once, rd_resp_valid stays 0.
REQ-033 Back-to-back RX frames (sb=2 then sb=1, no gap) with one outstanding -> one FIFO entry, scan frame ignored.
REQ-034 reset_n low during HEADER -> tx_pins=0 immediately; after release, a new request sends a complete frame.
